// File: rtl/chunked_subtractor.sv
// -----------------------------------------------------------------------------
// chunked_subtractor
//
// Multi-cycle unsigned subtractor. An operand set {ain, bin, bwin} is
// accepted in IDLE. The difference is then formed one CHUNK_WIDTH slice per
// cycle, least-significant slice first, by a single CHUNK_WIDTH+1 bit
// subtractor. The borrow is carried from one slice to the next in a register.
// After N = DATA_WIDTH/CHUNK_WIDTH cycles the result is presented in DONE
// until the consumer takes it.
//
// Ports
//   clk       : clock; all state changes on its rising edge
//   rst       : asynchronous, active-high reset
//   in_valid  : operand set valid
//   in_ready  : block can accept an operand set (high only in IDLE)
//   ain       : minuend, unsigned, DATA_WIDTH bits
//   bin       : subtrahend, unsigned, DATA_WIDTH bits
//   bwin      : borrow-in
//   out_valid : result valid (high only in DONE)
//   out_ready : consumer accepts result
//   dout      : difference, (ain - bin - bwin) mod 2^DATA_WIDTH
//   bwout     : borrow-out, set when ain < bin + bwin
//
// DATA_WIDTH must be an integer multiple of CHUNK_WIDTH.
// -----------------------------------------------------------------------------
module chunked_subtractor #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ain,
  input  logic [DATA_WIDTH-1:0] bin,
  input  logic                  bwin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  bwout
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic                   borrow_q;    // borrow into the slice being processed
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   bwout_q;

  logic [CHUNK_WIDTH-1:0] a_chunks [N];
  logic [CHUNK_WIDTH-1:0] b_chunks [N];
  logic [CHUNK_WIDTH-1:0] res_q    [N];

  logic [CHUNK_WIDTH-1:0] a_chunk;
  logic [CHUNK_WIDTH-1:0] b_chunk;
  logic [CHUNK_WIDTH:0]   chunk_d;     // {borrow-out, slice difference}
  logic                   last_chunk;
  logic                   accept;

  // in_ready is a register so it stays low throughout reset and only rises
  // on the first clock edge after reset is released.
  assign accept     = (state_q == IDLE) && in_ready_q && in_valid;
  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  // Slice views of the held operands, and result slices packed into dout.
  for (genvar gi = 0; gi < N; gi++) begin : g_slices
    assign a_chunks[gi] = a_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign b_chunks[gi] = b_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign dout[gi*CHUNK_WIDTH +: CHUNK_WIDTH] = res_q[gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_q[gi] <= '0;
      end else if (accept) begin
        res_q[gi] <= '0;
      end else if ((state_q == CALC) && (cnt_q == CNT_W'(gi))) begin
        res_q[gi] <= chunk_d[CHUNK_WIDTH-1:0];
      end
    end
  end

  // The one shared slice subtractor. The extra top bit goes to 1 exactly
  // when the slice minuend is smaller than subtrahend plus incoming borrow.
  assign a_chunk = a_chunks[cnt_q];
  assign b_chunk = b_chunks[cnt_q];
  assign chunk_d = {1'b0, a_chunk} - {1'b0, b_chunk}
                 - {{CHUNK_WIDTH{1'b0}}, borrow_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      bwout_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q        <= ain;
            b_q        <= bin;
            borrow_q   <= bwin;   // slice 0 starts from the external borrow
            cnt_q      <= '0;
            bwout_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        CALC: begin
          borrow_q <= chunk_d[CHUNK_WIDTH];
          if (last_chunk) begin
            cnt_q       <= '0;
            bwout_q     <= chunk_d[CHUNK_WIDTH];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          // Result held here; in_valid is ignored until it is consumed.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bwout     = bwout_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// -----------------------------------------------------------------------------
// tb_chunked_subtractor
//
// Directed vector table plus hand-written sequences for reset, backpressure
// and reset during calculation, followed by a short random regression with
// consumer stalls checked against a DATA_WIDTH+1 bit reference subtraction.
// -----------------------------------------------------------------------------
module tb_chunked_subtractor;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int LAT = DW / CW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] ain;
  logic [DW-1:0] bin;
  logic          bwin;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          bwout;

  int errors = 0;
  int checks = 0;

  chunked_subtractor #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .bwin      (bwin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .bwout     (bwout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          bw;
    logic [DW-1:0] exp_d;
    logic          exp_bw;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents operands for one accept edge,
  // then scrambles the inputs so a leak into the in-flight result shows.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bw);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    ain = a; bin = b; bwin = bw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ain = $urandom; bin = $urandom; bwin = 1'($urandom_range(0, 1));
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  // Counts cycles from the accept edge until out_valid, with a bound.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_consume", 64'(out_valid), 64'd0);
  endtask

  task automatic run_vec(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic bw, input logic [DW-1:0] exp_d, input logic exp_bw);
    int lat;
    start_op(a, b, bw);
    wait_result(lat);
    chk("latency", 64'(lat), 64'(LAT));
    chk("dout", 64'(dout), 64'(exp_d));
    chk("bwout", 64'(bwout), 64'(exp_bw));
    $display("vec %0d: %h - %h - %0d -> dout=%h bwout=%0d lat=%0d", idx, a, b, bw, dout, bwout, lat);
    consume();
  endtask

  initial begin
    int lat;
    logic saw_valid;
    logic [DW:0] model;
    logic [DW-1:0] ra, rb, hold_d;
    logic rbw, hold_bw;
    int stall;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0};
    vecs[7] = '{32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ain = '0; bin = '0; bwin = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_bwout", 64'(bwout), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_release", 64'(in_ready), 64'd1);
    $display("reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);

    // Directed table
    for (int i = 0; i < 10; i++)
      run_vec(i, vecs[i].a, vecs[i].b, vecs[i].bw, vecs[i].exp_d, vecs[i].exp_bw);

    // Backpressure: 5 stalled cycles in DONE with new operands on the inputs
    start_op(32'h0000_0100, 32'h0000_0001, 1'b0);
    wait_result(lat);
    chk("bp_latency", 64'(lat), 64'(LAT));
    chk("bp_dout", 64'(dout), 64'h0000_00FF);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      ain = $urandom; bin = $urandom; bwin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("bp_hold_dout", 64'(dout), 64'h0000_00FF);
      chk("bp_hold_bwout", 64'(bwout), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    ain = 32'h0000_0300; bin = 32'h0000_01FF; bwin = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", 64'(in_ready), 64'd0);
    wait_result(lat);
    chk("bp_next_latency", 64'(lat), 64'(LAT));
    chk("bp_next_dout", 64'(dout), 64'h0000_0100);
    chk("bp_next_bwout", 64'(bwout), 64'd0);
    $display("backpressure: next dout=%h bwout=%0d", dout, bwout);
    consume();

    // Reset while slice 2 is being processed
    start_op(32'h0000_0000, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_dout", 64'(dout), 64'd0);
    chk("midrst_bwout", 64'(bwout), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_out_valid", 64'(saw_valid), 64'd0);
    chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
    $display("reset mid-calc: saw_valid=%0d in_ready=%0d", saw_valid, in_ready);
    run_vec(100, 32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0);

    // Random regression with consumer stalls
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom; rb = $urandom; rbw = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      model = {1'b0, ra} - {1'b0, rb} - {{DW{1'b0}}, rbw};
      start_op(ra, rb, rbw);
      wait_result(lat);
      chk("rnd_latency", 64'(lat), 64'(LAT));
      chk("rnd_result", 64'({bwout, dout}), 64'(model));
      hold_d = dout; hold_bw = bwout;
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
      end
      chk("rnd_hold", 64'({bwout, dout, out_valid}), 64'({model, 1'b1}));
      if (i % 200 == 0)
        $display("rnd %0d: %h - %h - %0d -> {bw,d}=%h stall=%0d", i, ra, rb, rbw, {bwout, dout}, stall);
      consume();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
